// File: rtl/seq_adder_arbiter.sv
// Two-requester wide adder built on a single shared 4-bit slice.
// Round-robin grant, WIDTH/4 slice cycles per add, then a one-cycle done pulse.
module seq_adder_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] a0_i,
    input  logic [WIDTH-1:0] b0_i,
    input  logic [WIDTH-1:0] a1_i,
    input  logic [WIDTH-1:0] b1_i,
    input  logic             cin0_i,
    input  logic             cin1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             done_o,
    output logic             done_id_o
);

    localparam int SLICES = WIDTH / 4;
    localparam int KW     = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_id_q;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             done_q;
    logic             done_id_q;
    logic             busy_q;

    logic [3:0]       a_sl [SLICES];
    logic [3:0]       b_sl [SLICES];
    logic [4:0]       slice_d;

    // Grant is combinational so a requester sees it in the cycle it is accepted.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (state_q == IDLE && !rst_i) begin
            if (req0_i && req1_i) begin
                gnt0_o = last_id_q;
                gnt1_o = !last_id_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
            assign a_sl[gi] = a_q[4*gi +: 4];
            assign b_sl[gi] = b_q[4*gi +: 4];
        end
    endgenerate

    assign slice_d = {1'b0, a_sl[k_q]} + {1'b0, b_sl[k_q]} + {4'b0000, carry_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            last_id_q <= 1'b1;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            k_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0_o || gnt1_o) begin
                        a_q       <= gnt1_o ? a1_i : a0_i;
                        b_q       <= gnt1_o ? b1_i : b0_i;
                        carry_q   <= gnt1_o ? cin1_i : cin0_i;
                        id_q      <= gnt1_o;
                        last_id_q <= gnt1_o;
                        k_q       <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ADD;
                    end
                end
                ADD: begin
                    sum_q[{k_q, 2'b00} +: 4] <= slice_d[3:0];
                    carry_q                  <= slice_d[4];
                    k_q                      <= k_q + KW'(1);
                    if (k_q == LAST_K) begin
                        cout_q    <= slice_d[4];
                        done_q    <= 1'b1;
                        done_id_q <= id_q;
                        k_q       <= '0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;

endmodule

// File: tb/tb_seq_adder_arbiter.sv
// Directed bench for seq_adder_arbiter: table of single requests plus
// hand-written arbitration, busy-window and mid-operation reset sequences.
module tb_seq_adder_arbiter;

    localparam int W = 16;
    localparam int LAT = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         cin0, cin1;
    logic         gnt0, gnt1, busy, cout, done, done_id;
    logic [W-1:0] sum;

    int passed = 0;
    int total  = 0;

    seq_adder_arbiter #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1),
        .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
        .cin0_i(cin0), .cin1_i(cin1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .busy_o(busy),
        .sum_o(sum), .cout_o(cout), .done_o(done), .done_id_o(done_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic drive_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        if (id) begin a1 = a; b1 = b; cin1 = cin; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; cin0 = cin; req0 = 1'b1; end
    endtask

    task automatic wait_gnt(input logic id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if ((id ? gnt1 : gnt0) === 1'b1) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
    endtask

    // Counts rising edges after the accept edge until done is seen.
    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic run_txn(input string name, input logic id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] es, input logic ec);
        bit ok;
        int cyc;
        @(negedge clk);
        drive_req(id, a, b, cin);
        #1;
        wait_gnt(id, ok);
        chk({name, "_gnt"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        if (id) req1 = 1'b0; else req0 = 1'b0;
        chk({name, "_busy"}, 32'(busy), 32'd1);
        wait_done(cyc, ok);
        chk({name, "_done_seen"}, 32'(ok), 32'd1);
        chk({name, "_latency"}, 32'(cyc), 32'(LAT));
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
        chk({name, "_done_id"}, 32'(done_id), 32'(id));
        $display("txn %s: id=%0d a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d",
                 name, id, a, b, cin, sum, cout, cyc);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit ok, bad;
        int cyc;

        vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
        vecs[1] = '{1'b1, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[5] = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};

        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; cin0 = 1'b0; cin1 = 1'b0;

        // Reset state with a request pending
        repeat (2) @(negedge clk);
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_gnt0", 32'(gnt0), 32'd1);
        chk("rel_gnt1", 32'(gnt1), 32'd0);
        req0 = 1'b0;

        for (int i = 0; i < 7; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].s, vecs[i].c);

        // Arbitration: fresh reset puts the pointer at 1, so req0 wins first
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        drive_req(1'b0, 16'h0001, 16'h0001, 1'b0);
        drive_req(1'b1, 16'h8000, 16'h8000, 1'b0);
        #1;
        chk("arb1_gnt0", 32'(gnt0), 32'd1);
        chk("arb1_gnt1", 32'(gnt1), 32'd0);
        @(posedge clk); #1; req0 = 1'b0;
        wait_done(cyc, ok);
        chk("arb1_done_seen", 32'(ok), 32'd1);
        chk("arb1_done_id", 32'(done_id), 32'd0);
        chk("arb1_sum", 32'(sum), 32'h0002);
        chk("arb1_cout", 32'(cout), 32'd0);
        $display("txn arb1: done_id=%0d sum=%h cout=%0d", done_id, sum, cout);
        chk("arb_done_no_gnt1", 32'(gnt1), 32'd0);
        @(negedge clk); #1;
        chk("arb2_gnt1", 32'(gnt1), 32'd1);
        @(posedge clk); #1; req1 = 1'b0;
        wait_done(cyc, ok);
        chk("arb2_done_seen", 32'(ok), 32'd1);
        chk("arb2_done_id", 32'(done_id), 32'd1);
        chk("arb2_sum", 32'(sum), 32'h0000);
        chk("arb2_cout", 32'(cout), 32'd1);
        $display("txn arb2: done_id=%0d sum=%h cout=%0d", done_id, sum, cout);
        @(negedge clk);
        drive_req(1'b0, 16'h0001, 16'h0001, 1'b0);
        drive_req(1'b1, 16'h0001, 16'h0001, 1'b0);
        #1;
        chk("arb3_gnt0", 32'(gnt0), 32'd1);
        chk("arb3_gnt1", 32'(gnt1), 32'd0);
        $display("txn arb3: gnt0=%0d gnt1=%0d", gnt0, gnt1);
        req0 = 1'b0; req1 = 1'b0;

        // Request arriving during ADD waits until the first IDLE cycle after DONE
        @(negedge clk);
        drive_req(1'b0, 16'h0100, 16'h0200, 1'b0);
        #1;
        chk("busy_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1; req0 = 1'b0;
        @(posedge clk); #1;
        drive_req(1'b1, 16'h1111, 16'h2222, 1'b1);
        bad = 1'b0; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (gnt1 !== 1'b0) bad = 1'b1;
            @(negedge clk);
            if (gnt1 !== 1'b0) bad = 1'b1;
            if (done === 1'b1) ok = 1'b1;
        end
        chk("busy_no_early_gnt1", 32'(bad), 32'd0);
        chk("busy_first_done", 32'(ok), 32'd1);
        chk("busy_first_sum", 32'(sum), 32'h0300);
        chk("busy_first_id", 32'(done_id), 32'd0);
        @(negedge clk); #1;
        chk("busy_gnt1_after", 32'(gnt1), 32'd1);
        @(posedge clk); #1; req1 = 1'b0;
        wait_done(cyc, ok);
        chk("busy_second_done", 32'(ok), 32'd1);
        chk("busy_second_lat", 32'(cyc), 32'(LAT));
        chk("busy_second_sum", 32'(sum), 32'h3334);
        chk("busy_second_id", 32'(done_id), 32'd1);
        $display("txn busy: done_id=%0d sum=%h cout=%0d", done_id, sum, cout);

        // Reset in the second ADD cycle aborts with no done
        @(negedge clk);
        drive_req(1'b0, 16'h00FF, 16'h0001, 1'b0);
        #1;
        wait_gnt(1'b0, ok);
        chk("abort_gnt0", 32'(ok), 32'd1);
        @(posedge clk); #1; req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk); rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("abort_no_done", 32'(bad), 32'd0);
        run_txn("after_abort", 1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/seq_adder_arbiter.md
# seq_adder_arbiter

Shares one internal 4-bit adder slice between two requesters. Each accepted request adds two WIDTH-bit operands over WIDTH/4 cycles, one 4-bit slice per cycle, least-significant slice first, with the carry held in a register between slices. Round-robin arbitration picks the requester. The block sits between requesting logic and the adder datapath. It turns the combinational 4-bit adder into a shared, multi-cycle wide adder with a req/gnt/done handshake.

## Interface
Parameters:
- WIDTH, 16, operand width. Must be a multiple of 4 and ≥ 4. SLICES = WIDTH/4 is derived from it.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  request from requester 0/1. Held high until the requester samples its gnt high.
- a0, b0, a1, b1  in  WIDTH  operands per requester. Must be stable while req is high.
- cin0, cin1  in  1  carry-in per requester.
- gnt0, gnt1  out  1  grant. Combinational, high only in IDLE for the selected requester. The request is accepted on the clock edge where gnt is high.
- busy  out  1  high whenever the state is not IDLE.
- sum  out  WIDTH  result register.
- cout  out  1  carry-out of the most-significant slice.
- done  out  1  one-cycle pulse; sum/cout/done_id are valid in this cycle.
- done_id  out  1  index of the requester whose result is presented.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_id. last_id is the round-robin pointer and resets to 1, so req0 wins first.
  - At the accept edge: latch a, b, cin and the id; set the slice index to 0; set the carry register to cin; update last_id; go to ADD.
- ADD, slice index k:
  - Slice computes {c, s} = a[4k+3:4k] + b[4k+3:4k] + carry. This is a correct 4-bit add including carry-in.
  - At the edge: sum[4k+3:4k] <= s, carry <= c, k <= k+1.
  - After slice SLICES-1: cout <= c and go to DONE.
- DONE: done=1 and done_id=latched id for one cycle, then IDLE. No grant is issued in DONE.
- sum/cout hold the last completed result. During ADD, sum slices are overwritten progressively, so sum is only guaranteed correct while done=1.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Requests arriving during ADD/DONE are not granted and wait. A req that drops before its gnt is simply not served.

## Timing
- Reset values: state IDLE, last_id=1, sum=0, cout=0, done=0, done_id=0, busy=0, carry=0, k=0. gnt0/gnt1 are 0 while rst is high.
- rst asserted mid-ADD or in DONE aborts immediately. No done is produced for the aborted request. After release, operation restarts from IDLE.
- Latency: with the accept edge at edge 0, done is high in the cycle after edge SLICES (edge SLICES+1 returns to IDLE). For WIDTH=16, done goes high 4 cycles after acceptance.
- busy rises in the cycle after the accept edge and falls with the return to IDLE.
- Back-to-back: the next grant is possible in the first IDLE cycle after DONE. Minimum request spacing is SLICES+2 cycles.
- gnt is combinational from req and state. There is no combinational path from a/b to any output.

## Test plan
- Reset: hold rst, drive req0=1 → gnt0=gnt1=0, sum=0, cout=0, done=0, busy=0. Release rst → gnt0=1 in the same cycle.
- Single request, WIDTH=16: req0, a0=0x1234, b0=0x0FFF, cin0=0 → done 4 cycles after accept, sum=0x2233, cout=0, done_id=0.
- Carry chain:
  - a=0x0FFF, b=0x0001, cin=0 → 0x1000, cout=0.
  - a=0xFFFF, b=0x0001, cin=0 → 0x0000, cout=1.
  - a=0xFFFF, b=0xFFFF, cin=1 → 0xFFFF, cout=1.
  - a=0, b=0, cin=1 → 0x0001.
- Arbitration: after reset, raise req0 (1+1, cin=0) and req1 (0x8000+0x8000, cin=0) together.
  - Expected: gnt0 first, done_id=0, sum=0x0002; then gnt1, done_id=1, sum=0x0000, cout=1.
  - Next simultaneous pair → req0 granted again, since last_id=1.
- Request during busy: req1 raised in the second ADD cycle → gnt1 not asserted until the first IDLE cycle after DONE. Its result is correct.
- Reset mid-operation: assert rst during the second ADD cycle → busy=0 and no done. A fresh req1 (0x0005+0x0003, cin=0) completes with sum=0x0008, done_id=1.
